// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder/subtractor built around one full-adder slice.
// Operands are loaded in parallel on start, then processed LSB-first, one bit per cycle.
// The result registers update once, at the end of the operation.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - launch request, sampled only in idle
//   sub    - 0: a + b + c_in, 1: a - b (c_in ignored)
//   a, b   - WIDTH-bit operands, sampled with start
//   c_in   - carry-in for add, sampled with start
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when sum/c_out/ovf update
//   sum    - result of the last completed operation
//   c_out  - carry out of the MSB (for subtract, 1 means no borrow)
//   ovf    - two's-complement overflow
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] acc_shift;

  // The single full-adder slice.
  always_comb begin
    s_bit  = opa_q[0] ^ opb_q[0] ^ carry_q;
    c_next = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  end

  // New sum bit enters at the MSB; after WIDTH shifts the LSB result sits at bit 0.
  // Written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    acc_shift            = acc_q >> 1;
    acc_shift[WIDTH-1]   = s_bit;
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          opa_d   = a;
          // Subtract as a + ~b + 1.
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
        end
      end
      StRun: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = acc_shift;
        carry_d = c_next;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = acc_shift;
          c_out_d = c_next;
          // carry_q is the carry entering the MSB on this last bit.
          ovf_d   = carry_q ^ c_next;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 and WIDTH=1 instances on a shared clock/reset.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8, sub8, c_in8;
  logic [7:0] a8, b8;
  logic       busy8, done8, c_out8, ovf8;
  logic [7:0] sum8;

  logic       start1, sub1, c_in1;
  logic [0:0] a1, b1;
  logic       busy1, done1, c_out1, ovf1;
  logic [0:0] sum1;

  int n_vec;
  int n_err;

  logic [7:0] prev8;
  logic [7:0] prev1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .c_in  (c_in8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .c_out (c_out8),
    .ovf   (ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .sub   (sub1),
    .a     (a1),
    .b     (b1),
    .c_in  (c_in1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .c_out (c_out1),
    .ovf   (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       s;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as written.
  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic ci, input logic s, output logic [7:0] es,
                                output logic ec, output logic eo);
    int unsigned mask, bb, t;
    int          sa, sb, r, lim;
    mask = (32'd1 << w) - 32'd1;
    bb   = {24'd0, b};
    if (s) bb = ~bb;
    bb   = bb & mask;
    t    = ({24'd0, a} & mask) + bb + (s ? 32'd1 : {31'd0, ci});
    es   = 8'(t & mask);
    ec   = ((t >> w) & 32'd1) != 0;
    lim  = 1 << (w - 1);
    sa   = int'({24'd0, a} & mask);
    sb   = int'({24'd0, b} & mask);
    if (sa >= lim) sa -= 2 * lim;
    if (sb >= lim) sb -= 2 * lim;
    r    = s ? (sa - sb) : (sa + sb + int'(ci));
    eo   = (r >= lim) || (r < -lim);
  endfunction

  task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic s, input logic st);
    if (w == 8) begin
      a8 = a; b8 = b; c_in8 = ci; sub8 = s; start8 = st;
    end else begin
      a1 = a[0]; b1 = b[0]; c_in1 = ci; sub1 = s; start1 = st;
    end
  endtask

  function automatic logic rd_busy(input int w);
    return (w == 8) ? busy8 : busy1;
  endfunction
  function automatic logic rd_done(input int w);
    return (w == 8) ? done8 : done1;
  endfunction
  function automatic logic [7:0] rd_sum(input int w);
    return (w == 8) ? sum8 : {7'd0, sum1};
  endfunction
  function automatic logic rd_cout(input int w);
    return (w == 8) ? c_out8 : c_out1;
  endfunction
  function automatic logic rd_ovf(input int w);
    return (w == 8) ? ovf8 : ovf1;
  endfunction

  // One operation with start pulsed; checks latency, busy length, result hold and done width.
  // Operands are scrambled right after the launch edge to show they are not re-sampled.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic s, output logic [7:0] osum, output logic oc,
                        output logic oo);
    int         lat, bcnt, hold_bad;
    logic [7:0] held;
    held = (w == 8) ? prev8 : prev1;
    @(negedge clk);
    drive(w, a, b, ci, s, 1'b1);
    @(negedge clk);
    drive(w, ~a, ~b, ~ci, ~s, 1'b0);
    lat = -1; bcnt = 0; hold_bad = 0;
    for (int c = 0; c < w + 6; c++) begin
      if (rd_busy(w)) begin
        bcnt++;
        if (rd_sum(w) !== held) hold_bad++;
      end
      if (rd_done(w)) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk("latency", lat, w);
    chk("busy_cycles", bcnt, w);
    chk("sum_hold_run", hold_bad, 0);
    osum = rd_sum(w);
    oc   = rd_cout(w);
    oo   = rd_ovf(w);
    @(negedge clk);
    chk("done_width", int'(rd_done(w)), 0);
  endtask

  // start held high with operands changing every cycle.
  task automatic cont(input int w, input int n);
    int         launch_c, nl, nd, hold_bad;
    logic [7:0] ra, rb, held, pend_s, es;
    logic       rc, rs, pb, pend_c, pend_o, ec, eo;
    logic [7:0] drv_a, drv_b;
    logic       drv_c, drv_s;
    held = (w == 8) ? prev8 : prev1;
    pb = 1'b0; launch_c = -1; nl = 0; nd = 0; hold_bad = 0;
    pend_s = '0; pend_c = 1'b0; pend_o = 1'b0;
    @(negedge clk);
    for (int c = 0; c < n; c++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      drive(w, ra, rb, rc, rs, 1'b1);
      drv_a = ra; drv_b = rb; drv_c = rc; drv_s = rs;
      @(negedge clk);
      if (rd_busy(w) && !pb) begin
        model(w, drv_a, drv_b, drv_c, drv_s, es, ec, eo);
        pend_s = es; pend_c = ec; pend_o = eo;
        nl++;
        if (launch_c >= 0) chk("launch_period", c - launch_c, w + 2);
        launch_c = c;
      end
      if (rd_busy(w) && rd_sum(w) !== held) hold_bad++;
      if (rd_done(w)) begin
        nd++;
        chk("cont_sum", int'(rd_sum(w)), int'(pend_s));
        chk("cont_cout", int'(rd_cout(w)), int'(pend_c));
        chk("cont_ovf", int'(rd_ovf(w)), int'(pend_o));
        held = pend_s;
      end
      pb = rd_busy(w);
    end
    drive(w, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("cont_launches", nl, n / (w + 2));
    chk("cont_dones", nd, n / (w + 2));
    chk("cont_sum_hold", hold_bad, 0);
    if (w == 8) prev8 = held; else prev1 = held;
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] osum, es, ra, rb;
    logic       oc, oo, ec, eo, rc, rs;
    int         ndone;

    n_vec = 0; n_err = 0; prev8 = '0; prev1 = '0;
    rst = 1'b1;
    drive(8, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    drive(1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    tbl[0] = '{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

    #3;
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_outs8", int'({sum8, c_out8, ovf8}), 0);
    chk("rst_outs1", int'({busy1, done1, sum1, c_out1, ovf1}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(8, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, osum, oc, oo);
      chk($sformatf("tbl%0d_sum", i), int'(osum), int'(tbl[i].e_sum));
      chk($sformatf("tbl%0d_cout", i), int'(oc), int'(tbl[i].e_cout));
      chk($sformatf("tbl%0d_ovf", i), int'(oo), int'(tbl[i].e_ovf));
      prev8 = tbl[i].e_sum;
    end

    // Reset between edges after three RUN cycles; last result was 8'h80 with ovf=1.
    @(negedge clk);
    drive(8, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy8), 0);
    chk("midrst_done", int'(done8), 0);
    chk("midrst_sum", int'(sum8), 0);
    chk("midrst_cout", int'(c_out8), 0);
    chk("midrst_ovf", int'(ovf8), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev8 = '0; prev1 = '0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_op(8, 8'h10, 8'h20, 1'b0, 1'b0, osum, oc, oo);
    chk("postrst_sum", int'(osum), 8'h30);
    chk("postrst_cout", int'(oc), 0);
    prev8 = 8'h30;

    cont(8, 50);
    cont(1, 30);

    for (int w = 8; w >= 1; w -= 7) begin
      for (int i = 0; i < 500; i++) begin
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        model(w, ra, rb, rc, rs, es, ec, eo);
        run_op(w, ra, rb, rc, rs, osum, oc, oo);
        chk($sformatf("rnd_w%0d_sum", w), int'(osum), int'(es));
        chk($sformatf("rnd_w%0d_cout", w), int'(oc), int'(ec));
        chk($sformatf("rnd_w%0d_ovf", w), int'(oo), int'(eo));
        if (w == 8) prev8 = es; else prev1 = es;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, parametrised successor to the single-bit full-adder cell. One full-adder slice, a carry flip-flop and operand/result shift registers compute a WIDTH-bit add or subtract over WIDTH clock cycles. Operands and results are fully parallel, with a start/busy/done handshake. It sits wherever area matters more than latency, e.g. slow control-path arithmetic feeding counters and comparators.

## Interface

- `WIDTH`, default 8: operand and result width in bits. Legal values are WIDTH >= 1.
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new operation. Sampled only in IDLE.
- `sub`  in  1: 0 computes `a + b + c_in`; 1 computes `a - b` as `a + ~b + 1`, with `c_in` ignored.
- `a`  in  WIDTH: operand A, sampled with `start`.
- `b`  in  WIDTH: operand B, sampled with `start`.
- `c_in`  in  1: carry-in for add, sampled with `start`.
- `busy`  out  1: high while bits are being processed (RUN state).
- `done`  out  1: one-cycle pulse when the result registers update.
- `sum`  out  WIDTH: result of the last completed operation.
- `c_out`  out  1: carry out of the MSB. For subtract, 1 means no borrow.
- `ovf`  out  1: two's-complement overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation

- FSM states: IDLE, RUN, DONE. All transitions occur on the `clk` rising edge.
- **IDLE with `start`=1**, on the sampling edge:
  - load `opa`=`a` and `opb`=(`sub` ? ~`b` : `b`);
  - set `carry`=(`sub` ? 1 : `c_in`);
  - clear the bit counter `cnt`;
  - go to RUN.
- **IDLE with `start`=0**: stay in IDLE.
- **Each RUN edge** processes one bit:
  - `s` = `opa[0]` ^ `opb[0]` ^ `carry`;
  - `carry` <= majority(`opa[0]`, `opb[0]`, `carry`);
  - `opa` and `opb` shift right;
  - `s` shifts into the MSB of the internal `acc` shift register;
  - `cnt` increments.
- **Last RUN edge** (`cnt` == WIDTH-1):
  - go to DONE;
  - `sum` <= final `acc` including this bit;
  - `c_out` <= new carry;
  - `ovf` <= (carry entering this bit) ^ (new carry).
- **DONE**: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `start` is ignored in RUN and DONE. There is no queuing.
- `sum`, `c_out` and `ovf` change only on the RUN→DONE edge. They hold their previous values throughout RUN, DONE and IDLE.
- `busy` = (state == RUN). `done` = (state == DONE). Both are decoded from registered state, so neither has a combinational path from inputs.
- Arithmetic: modulo 2^WIDTH. The counter is $clog2(WIDTH+1) bits wide; for WIDTH=1 it is 1 bit.
- WIDTH=1: a single RUN cycle. `ovf` = initial carry XOR `c_out`.
- **Reset** (asynchronous, at any time including mid-RUN):
  - state = IDLE;
  - `busy`, `done`, `sum`, `c_out`, `ovf` all 0;
  - `opa`, `opb`, `acc`, `carry`, `cnt` all 0;
  - the in-flight operation is discarded and produces no `done`.

## Timing

- Call the edge that samples `start` in IDLE edge 0.
  - `busy` is high from after edge 0 until edge WIDTH, i.e. for WIDTH cycles.
  - `done`, `sum`, `c_out` and `ovf` become valid after edge WIDTH.
  - `done` drops after edge WIDTH+1.
- Latency from the `start` sample to `done` high is WIDTH cycles.
- Minimum start-to-start period is WIDTH+2 cycles. With `start` held high continuously, operations launch on edges 0, WIDTH+2, 2·(WIDTH+2), and so on.
- Inputs `a`, `b`, `sub` and `c_in` may change freely after edge 0 without affecting the result.
- Reset deassertion must meet recovery/removal timing against `clk`. The first `start` can be sampled on the first edge after deassertion.

## Test plan

- **Add with signed overflow** (WIDTH=8): `a`=8'h3C, `b`=8'h5A, `c_in`=0, `sub`=0 -> `sum`=8'h96, `c_out`=0, `ovf`=1. `done` rises exactly 8 cycles after the start edge, and `busy` is high for 8 cycles.
- **Add with carry and c_in** (WIDTH=8):
  - 8'hFF + 8'h01, `c_in`=0 -> `sum`=8'h00, `c_out`=1, `ovf`=0.
  - 8'h00 + 8'h00, `c_in`=1 -> `sum`=8'h01, `c_out`=0.
- **Subtract**, with `c_in` set to 1 to prove it is ignored:
  - 8'h05 - 8'h07 -> `sum`=8'hFE, `c_out`=0, `ovf`=0.
  - 8'h80 - 8'h01 -> `sum`=8'h7F, `c_out`=1, `ovf`=1.
- **Handshake robustness**:
  - Hold `start`=1 continuously with changing operands. Operations must launch every 10 cycles, and each `done` must reflect the operands present at its own launch edge.
  - Between launches, `sum` must stay stable during RUN.
- **Reset mid-RUN**: assert `rst` asynchronously (between edges) after 3 RUN cycles.
  - All outputs must go to 0 immediately, and `done` must never pulse for that operation.
  - After deassertion, 8'h10 + 8'h20 -> `sum`=8'h30.
- **Randomised sweep** at WIDTH=8 and WIDTH=1: 500 random `a`, `b`, `c_in`, `sub` each, compared against a behavioural `{c_out, sum}` model and a signed overflow model. At WIDTH=1, `done` must come 1 cycle after start, with a period of 3.
